// File: rtl/perc_table_pkg.sv
// Shared types and helpers for the self-training perceptron weight table.
// Build option: PERC_TABLE_BYPASS_EN (see perc_table.sv).
package perc_table_pkg;

    // INIT is the post-reset row sweep; the training states follow it.
    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        T_READ  = 2'd2,
        T_WRITE = 2'd3
    } train_state_e;

    // Integer form of floor(1.93*hist_len + 14).
    function automatic int theta_default(input int hist_len);
        return (193 * hist_len) / 100 + 14;
    endfunction

    // Saturating +/-1 step; the limits are symmetric at +/-wmax.
    function automatic int sat_step(input int weight, input logic dir, input int wmax);
        if (dir) begin
            return (weight >= wmax) ? wmax : weight + 1;
        end
        return (weight <= -wmax) ? -wmax : weight - 1;
    endfunction

endpackage

// File: rtl/perc_table_dot.sv
// Combinational signed dot product of one perceptron row against a history vector.
// Terms are sign-extended to SUM_W and reduced through a balanced binary tree.
module perc_dot #(
    parameter int W_BITS   = 8,
    parameter int HIST_LEN = 12,
    parameter int SUM_W    = 12
) (
    input  logic [HIST_LEN:0][W_BITS-1:0] weights,
    input  logic [HIST_LEN-1:0]           ghr,
    output logic signed [SUM_W-1:0]       sum
);

    localparam int N_TERMS = HIST_LEN + 1;
    localparam int LEVELS  = $clog2(N_TERMS);
    localparam int N_LEAF  = 1 << LEVELS;

    // Heap layout: node k has children 2k+1 and 2k+2; leaves start at N_LEAF-1.
    logic signed [SUM_W-1:0] node [2*N_LEAF-1];

    function automatic logic signed [SUM_W-1:0] sext(input logic [W_BITS-1:0] w);
        return {{(SUM_W-W_BITS){w[W_BITS-1]}}, w};
    endfunction

    always_comb begin
        for (int k = 0; k < 2*N_LEAF-1; k++) begin
            node[k] = '0;
        end
        node[N_LEAF-1] = sext(weights[0]);
        for (int i = 0; i < HIST_LEN; i++) begin
            node[N_LEAF+i] = ghr[i] ? sext(weights[i+1]) : -sext(weights[i+1]);
        end
        for (int k = N_LEAF-2; k >= 0; k--) begin
            node[k] = node[2*k+1] + node[2*k+2];
        end
        sum = node[0];
    end

endmodule

// File: rtl/perc_table.sv
// Self-training perceptron weight table: 2-stage predict pipeline plus a threshold-rule train FSM.
// Build option: define PERC_TABLE_BYPASS_EN to forward T_WRITE weights into a same-row stage-1 read.
module perc_table
    import perc_table_pkg::*;
#(
    parameter int  W_BITS   = 8,
    parameter int  HIST_LEN = 12,
    parameter int  N_ROWS   = 16,
    parameter int  THETA    = theta_default(HIST_LEN),
    localparam int IDX_W    = $clog2(N_ROWS),
    localparam int SUM_W    = W_BITS + $clog2(HIST_LEN+1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_busy,

    input  logic                    pred_valid,
    input  logic [IDX_W-1:0]        pred_index,
    input  logic [HIST_LEN-1:0]     pred_ghr,
    output logic                    pred_out_valid,
    output logic signed [SUM_W-1:0] pred_sum,
    output logic                    pred_taken,

    // A train request transfers on a rising edge where train_valid && train_ready;
    // the request fields must be stable while train_valid is high and are latched at that edge.
    input  logic                    train_valid,
    output logic                    train_ready,
    input  logic [IDX_W-1:0]        train_index,
    input  logic [HIST_LEN-1:0]     train_ghr,
    input  logic                    train_taken,
    input  logic [SUM_W-1:0]        train_sum,
    output logic                    train_done,
    output logic                    train_upd,

    output train_state_e            dbg_state
);

    typedef logic [HIST_LEN:0][W_BITS-1:0] row_t;

    localparam int                      W_MAX    = 2**(W_BITS-1) - 1;
    localparam logic signed [SUM_W-1:0] THETA_S  = SUM_W'(THETA);
    localparam logic [IDX_W-1:0]        LAST_ROW = IDX_W'(N_ROWS-1);

    row_t table_q [N_ROWS];

    train_state_e            state_q, state_d;
    logic [IDX_W-1:0]        init_cnt_q;
    logic [IDX_W-1:0]        t_idx_q;
    logic [HIST_LEN-1:0]     t_ghr_q;
    logic                    t_taken_q;
    logic signed [SUM_W-1:0] t_sum_q;
    row_t                    t_row_q;
    row_t                    new_row;
    logic                    mispredict;
    logic                    low_conf;
    logic                    do_update;
    logic                    done_d;
    logic                    upd_d;

    row_t                    rd_row;
    logic                    s1_valid;
    row_t                    s1_row;
    logic [HIST_LEN-1:0]     s1_ghr;
    logic signed [SUM_W-1:0] dot_sum;

    assign init_busy   = (state_q == INIT);
    assign train_ready = (state_q == IDLE);
    assign dbg_state   = state_q;

    // Train when the reported sum picked the wrong direction or was not confident enough.
    assign mispredict = (~t_sum_q[SUM_W-1]) != t_taken_q;
    assign low_conf   = (t_sum_q <= THETA_S) && (t_sum_q >= -THETA_S);
    assign do_update  = mispredict || low_conf;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        upd_d   = 1'b0;
        case (state_q)
            INIT: begin
                if (init_cnt_q == LAST_ROW) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (train_valid) begin
                    state_d = T_READ;
                end
            end
            T_READ: begin
                if (do_update) begin
                    state_d = T_WRITE;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            T_WRITE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                upd_d   = 1'b1;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            t_idx_q    <= '0;
            t_ghr_q    <= '0;
            t_taken_q  <= 1'b0;
            t_sum_q    <= '0;
            t_row_q    <= '0;
            train_done <= 1'b0;
            train_upd  <= 1'b0;
        end else begin
            state_q    <= state_d;
            train_done <= done_d;
            train_upd  <= upd_d;
            if (state_q == INIT) begin
                init_cnt_q <= init_cnt_q + IDX_W'(1);
            end
            if (state_q == IDLE && train_valid) begin
                t_idx_q   <= train_index;
                t_ghr_q   <= train_ghr;
                t_taken_q <= train_taken;
                t_sum_q   <= $signed(train_sum);
            end
            if (state_q == T_READ) begin
                t_row_q <= table_q[t_idx_q];
            end
        end
    end

    always_comb begin
        new_row    = t_row_q;
        new_row[0] = W_BITS'(sat_step(int'($signed(t_row_q[0])), t_taken_q, W_MAX));
        for (int i = 0; i < HIST_LEN; i++) begin
            new_row[i+1] = W_BITS'(sat_step(int'($signed(t_row_q[i+1])),
                                            t_ghr_q[i] == t_taken_q, W_MAX));
        end
    end

    // Weight storage needs no reset: the INIT sweep clears every row before first use.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            table_q[init_cnt_q] <= '0;
        end else if (state_q == T_WRITE) begin
            table_q[t_idx_q] <= new_row;
        end
    end

    always_comb begin
        rd_row = table_q[pred_index];
`ifdef PERC_TABLE_BYPASS_EN
        if (state_q == T_WRITE && t_idx_q == pred_index) begin
            rd_row = new_row;
        end
`endif
    end

    perc_dot #(
        .W_BITS   (W_BITS),
        .HIST_LEN (HIST_LEN),
        .SUM_W    (SUM_W)
    ) u_dot (
        .weights (s1_row),
        .ghr     (s1_ghr),
        .sum     (dot_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_row         <= '0;
            s1_ghr         <= '0;
            pred_out_valid <= 1'b0;
            pred_sum       <= '0;
            pred_taken     <= 1'b0;
        end else begin
            s1_valid       <= pred_valid && (state_q != INIT);
            pred_out_valid <= s1_valid;
            if (pred_valid) begin
                s1_row <= rd_row;
                s1_ghr <= pred_ghr;
            end
            if (s1_valid) begin
                pred_sum   <= dot_sum;
                pred_taken <= ~dot_sum[SUM_W-1];
            end
        end
    end

endmodule
